reader_pie_encoder: RTL and testbench
=====================================

Name: reader_pie_encoder

Overview:
- Reader-side (interrogator) PIE encoder: the reader-to-tag half of the link that the tag's rx block decodes.
- Takes a serial command bit stream and produces the pulse-interval-encoded baseband `pie_out`: delimiter, data-0, RTcal, an optional TRcal, then the data symbols. It returns to CW (high) when the frame ends.
- Used in the reader emulator and as the stimulus source for tag-level benches, driving the tag `demodin` directly.

Parameters:
- CNT_W, 10, width of all symbol-length counters
- TARI, 25, data-0 symbol length in clk cycles
- DATA1, 44, data-1 symbol length in clk cycles
- PW, 12, low-pulse width in clk cycles, applied at the end of every symbol
- DELIM, 25, delimiter low length in clk cycles

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle frame request; ignored while busy
- full_preamble  in  1  1 = preamble with TRcal (Query); 0 = frame-sync only; latched on start
- trcal_len  in  10  TRcal symbol length in clk cycles; latched on start
- bit_valid  in  1  bit_data is valid
- bit_data  in  1  next command bit, msb first
- bit_last  in  1  qualifies bit_data as the final bit of the frame
- bit_ready  out  1  encoder is consuming a bit this cycle
- pie_out  out  1  PIE baseband; 1 = CW, 0 = attenuated
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse when a frame completes normally
- err  out  1  one-cycle pulse on a rejected start or a mid-frame underflow

Behaviour:
- Reset (asynchronous, active-low):
  - pie_out=1; busy, done, err and bit_ready all 0; FSM in IDLE; counters cleared.
  - Reset asserted mid-frame aborts immediately, with pie_out=1 on that edge.
- Derived length: RTCAL = TARI + DATA1, computed at CNT_W+1 bits.
  - Parameters must satisfy TARI>PW, DATA1>PW and RTCAL < 2^CNT_W.
  - A violation is an elaboration-time error.
- Symbol shape: a symbol of length L is L−PW cycles high, then PW cycles low.
- FSM states: IDLE, DELIM, SYM_HI, SYM_LO. Register sym_kind ∈ {D0, RTC, TRC, DATA} and the current bit value.
- IDLE:
  - start && trcal_len>PW (checked only when full_preamble=1): latch inputs; busy=1; next state DELIM; pie_out=0 from the next cycle.
  - start with full_preamble=1 and trcal_len≤PW: stay in IDLE; err=1 for one cycle.
- DELIM: DELIM cycles low, then SYM_HI with kind D0.
- Symbol order: D0 → RTC → (TRC if full_preamble) → DATA repeated.
- Bit fetch:
  - bit_ready=1 only on the last SYM_LO cycle of the RTC/TRC symbol that precedes data, and of each DATA symbol whose bit was not last.
  - The transfer occurs when bit_valid && bit_ready.
  - bit_valid=0 in that cycle is an underflow: err=1, busy=0, return to IDLE with pie_out=1 on the next cycle. This is an aborted frame; done is not asserted.
- A DATA symbol has length TARI for bit 0 and DATA1 for bit 1.
- Frame end: at the last SYM_LO cycle of the bit flagged bit_last, go to IDLE; on the next cycle pie_out=1, busy=0 and done=1 for one cycle.
- A zero-bit frame is not possible: the first fetched bit always starts a DATA symbol.
- start while busy is ignored, with no err pulse.
- Latency: start at edge n gives pie_out=0 at edge n+1. The frame-sync header lasts DELIM+TARI+RTCAL cycles before the first data symbol begins.
- All outputs are registered.

Decomposition:
- Shared package `pie_pkg`:
  - state enum {IDLE, DELIM, SYM_HI, SYM_LO};
  - sym_kind enum {D0, RTC, TRC, DATA};
  - localparam RTCAL.
- Sub-module `pie_symbol_timer`:
  - loads L and PW, counts down, and outputs phase (hi/lo) and last_cycle;
  - the top FSM sequences symbols and handles the bit handshake.

Test Plan:
- Frame-sync, one bit 0 (bit_last=1), defaults:
  - pie_out: 25 low, 13 high/12 low, 57 high/12 low, 13 high/12 low, then high;
  - done pulses at cycle 145 after start;
  - bit_ready high exactly once.
- Full preamble with trcal_len=100, bits 1,0,1:
  - after RTcal, 88 high/12 low;
  - then data 32h/12l, 13h/12l, 32h/12l;
  - done once; three bit_ready pulses.
- Underflow: bit_valid held 0 at the RTcal fetch cycle → err=1 for one cycle, pie_out=1 next cycle, busy=0, no done.
- Rejected start: full_preamble=1, trcal_len=12 → err pulse, pie_out stays 1, busy stays 0.
- start re-pulsed during DELIM and during a data symbol → waveform identical to the single-start run.
- Reset asserted during SYM_LO → pie_out=1 asynchronously. A start after release produces a clean full frame.

Source files
------------

// File: rtl/pie_pkg.sv
// Shared types and default timing for the reader-side PIE encoder.
package pie_pkg;

    localparam int CNT_W_DEF = 10;
    localparam int TARI_DEF  = 25;
    localparam int DATA1_DEF = 44;
    localparam int PW_DEF    = 12;
    localparam int DELIM_DEF = 25;

    typedef enum logic [1:0] {ST_IDLE, ST_DELIM, ST_SYM_HI, ST_SYM_LO} state_t;
    typedef enum logic [1:0] {K_D0, K_RTC, K_TRC, K_DATA} sym_kind_t;

    function automatic int rtcal_len(input int tari, input int data1);
        return tari + data1;
    endfunction

    localparam int RTCAL = rtcal_len(TARI_DEF, DATA1_DEF);

endpackage

// File: rtl/pie_symbol_timer.sv
// Symbol-length down-counter. It also exposes next-cycle phase and terminal
// count so the owner can register its outputs without an extra cycle of lag.
module pie_symbol_timer #(
    parameter int CNT_W = 10,
    parameter int PW    = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] len,
    output logic             last_cycle,
    output logic             phase_lo_nxt,
    output logic             last_cycle_nxt
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // cnt holds the cycles still to go after the current one
    always_comb begin
        if (load)
            cnt_nxt = len - CNT_W'(1);
        else if (cnt != '0)
            cnt_nxt = cnt - CNT_W'(1);
        else
            cnt_nxt = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else
            cnt <= cnt_nxt;
    end

    assign last_cycle     = (cnt == '0);
    assign phase_lo_nxt   = (cnt_nxt < CNT_W'(PW));
    assign last_cycle_nxt = (cnt_nxt == '0);

endmodule

// File: rtl/reader_pie_encoder.sv
// Reader-to-tag PIE encoder: delimiter, data-0, RTcal, optional TRcal, then
// one PIE symbol per fetched command bit; returns to CW when the frame ends.
module reader_pie_encoder
    import pie_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int TARI  = TARI_DEF,
    parameter int DATA1 = DATA1_DEF,
    parameter int PW    = PW_DEF,
    parameter int DELIM = DELIM_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             full_preamble,
    input  logic [CNT_W-1:0] trcal_len,
    input  logic             bit_valid,
    input  logic             bit_data,
    input  logic             bit_last,
    output logic             bit_ready,
    output logic             pie_out,
    output logic             busy,
    output logic             done,
    output logic             err
);

    // state     | meaning
    // ST_IDLE   | CW, waiting for start
    // ST_DELIM  | delimiter low period
    // ST_SYM_HI | high part of the current symbol
    // ST_SYM_LO | trailing PW-cycle low pulse of the current symbol

    localparam int              RTCAL_INT = rtcal_len(TARI, DATA1);
    localparam logic [CNT_W:0]  RTCAL_LEN = (CNT_W+1)'(RTCAL_INT);

    if (!(TARI > PW && DATA1 > PW && PW >= 1 && DELIM >= 1 &&
          RTCAL_INT < (1 << CNT_W))) begin : g_bad_params
        $error("reader_pie_encoder: illegal symbol timing parameters");
    end

    state_t           state, nxt_state;
    sym_kind_t        kind, nxt_kind;
    logic             cur_bit, nxt_bit;
    logic             last_bit, nxt_last_bit;
    logic             trc_en, nxt_trc;
    logic [CNT_W-1:0] trcal_q, nxt_trcal;

    logic             load;
    logic [CNT_W-1:0] len;
    logic             fetch, ev_done, ev_err, need_fetch;
    logic             tmr_last, tmr_lo_nxt, tmr_last_nxt;

    pie_symbol_timer #(.CNT_W(CNT_W), .PW(PW)) u_timer (
        .clk            (clk),
        .reset          (reset),
        .load           (load),
        .len            (len),
        .last_cycle     (tmr_last),
        .phase_lo_nxt   (tmr_lo_nxt),
        .last_cycle_nxt (tmr_last_nxt)
    );

    always_comb begin
        nxt_state    = state;
        nxt_kind     = kind;
        nxt_bit      = cur_bit;
        nxt_last_bit = last_bit;
        nxt_trc      = trc_en;
        nxt_trcal    = trcal_q;
        load         = 1'b0;
        len          = '0;
        fetch        = 1'b0;
        ev_done      = 1'b0;
        ev_err       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (full_preamble && trcal_len <= CNT_W'(PW)) begin
                        ev_err = 1'b1;
                    end else begin
                        load      = 1'b1;
                        len       = CNT_W'(DELIM);
                        nxt_state = ST_DELIM;
                        nxt_trc   = full_preamble;
                        nxt_trcal = trcal_len;
                    end
                end
            end
            ST_DELIM: begin
                if (tmr_last) begin
                    load      = 1'b1;
                    len       = CNT_W'(TARI);
                    nxt_kind  = K_D0;
                    nxt_state = ST_SYM_HI;
                end
            end
            default: begin
                if (tmr_last) begin
                    case (kind)
                        K_D0: begin
                            load     = 1'b1;
                            len      = RTCAL_LEN[CNT_W-1:0];
                            nxt_kind = K_RTC;
                        end
                        K_RTC: begin
                            if (trc_en) begin
                                load     = 1'b1;
                                len      = trcal_q;
                                nxt_kind = K_TRC;
                            end else begin
                                fetch = 1'b1;
                            end
                        end
                        K_TRC: fetch = 1'b1;
                        default: begin
                            if (last_bit) begin
                                nxt_state = ST_IDLE;
                                ev_done   = 1'b1;
                            end else begin
                                fetch = 1'b1;
                            end
                        end
                    endcase
                end
            end
        endcase

        if (fetch) begin
            if (bit_valid) begin
                load         = 1'b1;
                len          = bit_data ? CNT_W'(DATA1) : CNT_W'(TARI);
                nxt_kind     = K_DATA;
                nxt_bit      = bit_data;
                nxt_last_bit = bit_last;
            end else begin
                nxt_state = ST_IDLE;
                ev_err    = 1'b1;
            end
        end

        if (nxt_state == ST_SYM_HI || nxt_state == ST_SYM_LO)
            nxt_state = tmr_lo_nxt ? ST_SYM_LO : ST_SYM_HI;
    end

    // symbols whose final cycle hands over to a freshly fetched data bit
    always_comb begin
        need_fetch = (nxt_kind == K_RTC && !nxt_trc) || (nxt_kind == K_TRC) ||
                     (nxt_kind == K_DATA && !nxt_last_bit);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            kind      <= K_D0;
            cur_bit   <= 1'b0;
            last_bit  <= 1'b0;
            trc_en    <= 1'b0;
            trcal_q   <= '0;
            pie_out   <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            bit_ready <= 1'b0;
        end else begin
            state     <= nxt_state;
            kind      <= nxt_kind;
            cur_bit   <= nxt_bit;
            last_bit  <= nxt_last_bit;
            trc_en    <= nxt_trc;
            trcal_q   <= nxt_trcal;
            pie_out   <= !(nxt_state == ST_DELIM || nxt_state == ST_SYM_LO);
            busy      <= (nxt_state != ST_IDLE);
            done      <= ev_done;
            err       <= ev_err;
            bit_ready <= (nxt_state == ST_SYM_HI || nxt_state == ST_SYM_LO) &&
                         tmr_last_nxt && need_fetch;
        end
    end

endmodule

// File: tb/tb_reader_pie_encoder.sv
// Randomized bench for reader_pie_encoder against a symbol-list waveform model.
module tb_reader_pie_encoder;

    localparam int TARI  = 25;
    localparam int DATA1 = 44;
    localparam int PW    = 12;
    localparam int DELIM = 25;
    localparam int MAXC  = 4096;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       full_preamble = 1'b0;
    logic [9:0] trcal_len = '0;
    logic       bit_valid = 1'b0;
    logic       bit_data = 1'b0;
    logic       bit_last = 1'b0;
    logic       bit_ready, pie_out, busy, done, err;

    reader_pie_encoder dut (
        .clk(clk), .reset(reset), .start(start), .full_preamble(full_preamble),
        .trcal_len(trcal_len), .bit_valid(bit_valid), .bit_data(bit_data),
        .bit_last(bit_last), .bit_ready(bit_ready), .pie_out(pie_out),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    bit exp_pie [MAXC];
    bit exp_busy[MAXC];
    bit exp_done[MAXC];
    bit exp_err [MAXC];
    bit exp_rdy [MAXC];
    int m_len, m_hdr;

    bit tb_bits[16];
    int n_bits = 0;
    int drop_j = -1;
    int head = 0;
    bit took;

    bit chk_on = 1'b0;
    int idx = 0;
    int chk_len = 0;

    task automatic chk1(input string name, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s at t=%0t idx=%0d: got %0d, want %0d", name, $time, idx, act, exp_v);
        end
    endtask

    task automatic add_sym(input int l, inout int t);
        for (int i = 0; i < l; i++) begin
            exp_pie[t+i]  = (i >= l - PW) ? 1'b0 : 1'b1;
            exp_busy[t+i] = 1'b1;
        end
        t += l;
    endtask

    // Index k = outputs just after the k-th clock edge following the start edge.
    task automatic build_model(input bit fp, input int trcal, input int nb, input int drop);
        int t;
        for (int i = 0; i < MAXC; i++) begin
            exp_pie[i] = 1'b1; exp_busy[i] = 1'b0; exp_done[i] = 1'b0;
            exp_err[i] = 1'b0; exp_rdy[i] = 1'b0;
        end
        m_hdr = DELIM + TARI + TARI + DATA1 + (fp ? trcal : 0);
        if (fp && trcal <= PW) begin
            exp_err[0] = 1'b1;
            m_len = 1;
            return;
        end
        for (int i = 0; i < DELIM; i++) begin
            exp_pie[i] = 1'b0; exp_busy[i] = 1'b1;
        end
        t = DELIM;
        add_sym(TARI, t);
        add_sym(TARI + DATA1, t);
        if (fp) add_sym(trcal, t);
        for (int j = 0; j < nb; j++) begin
            exp_rdy[t-1] = 1'b1;
            if (j == drop) begin
                exp_err[t] = 1'b1;
                m_len = t + 1;
                return;
            end
            add_sym(tb_bits[j] ? DATA1 : TARI, t);
        end
        exp_done[t] = 1'b1;
        m_len = t + 1;
    endtask

    function automatic int count_rdy();
        int n = 0;
        for (int i = 0; i < MAXC; i++) n += int'(exp_rdy[i]);
        return n;
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            chk1("pie_out",   int'(pie_out),   int'(exp_pie[idx]));
            chk1("busy",      int'(busy),      int'(exp_busy[idx]));
            chk1("done",      int'(done),      int'(exp_done[idx]));
            chk1("err",       int'(err),       int'(exp_err[idx]));
            chk1("bit_ready", int'(bit_ready), int'(exp_rdy[idx]));
            idx++;
            if (idx >= chk_len) chk_on = 1'b0;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            took = bit_ready && bit_valid;
            @(posedge clk);
            #1;
            if (took) head++;
            bit_valid = (head < n_bits) && (head != drop_j);
            bit_data  = (head < n_bits && head < 16) ? tb_bits[head] : 1'($urandom);
            bit_last  = (head == n_bits - 1);
        end
    end

    task automatic launch(input bit fp, input int trcal, input int nb, input int drop);
        build_model(fp, trcal, nb, drop);
        chk_len = m_len + 3;
        n_bits = nb;
        drop_j = drop;
        head = 0;
        @(posedge clk); #1;
        start = 1'b1; full_preamble = fp; trcal_len = 10'(trcal);
        @(posedge clk); #1;
        start = 1'b0;
        full_preamble = 1'($urandom);
        trcal_len = 10'($urandom);
        idx = 0;
        chk_on = 1'b1;
    endtask

    task automatic run_frame(input bit fp, input int trcal, input int nb, input int drop,
                             input bit repulse);
        int r1, r2;
        launch(fp, trcal, nb, drop);
        r1 = repulse ? int'($urandom_range(0, 15)) : -1;
        r2 = (repulse && drop < 0) ? int'($urandom_range(m_hdr, m_len - 2)) - 3 : -1;
        for (int c = 0; c < chk_len + 8 && chk_on; c++) begin
            @(posedge clk); #1;
            start = (c == r1) || (c == r2);
        end
        start = 1'b0;
        chk1("frame_complete", int'(chk_on), 0);
    endtask

    initial begin
        #12;
        chk1("rst_pie_out",   int'(pie_out),   1);
        chk1("rst_busy",      int'(busy),      0);
        chk1("rst_done",      int'(done),      0);
        chk1("rst_err",       int'(err),       0);
        chk1("rst_bit_ready", int'(bit_ready), 0);
        #10 reset = 1'b1;

        // frame-sync, single bit 0
        tb_bits[0] = 1'b0;
        build_model(1'b0, 0, 1, -1);
        chk1("pin1_len",     m_len, 145);
        chk1("pin1_done144", int'(exp_done[144]), 1);
        chk1("pin1_lo38",    int'(exp_pie[38]), 0);
        chk1("pin1_hi50",    int'(exp_pie[50]), 1);
        chk1("pin1_lo107",   int'(exp_pie[107]), 0);
        chk1("pin1_hi131",   int'(exp_pie[131]), 1);
        chk1("pin1_lo143",   int'(exp_pie[143]), 0);
        chk1("pin1_rdy118",  int'(exp_rdy[118]), 1);
        chk1("pin1_nrdy",    count_rdy(), 1);
        run_frame(1'b0, 0, 1, -1, 1'b0);

        // full preamble, TRcal=100, bits 1,0,1
        tb_bits[0] = 1'b1; tb_bits[1] = 1'b0; tb_bits[2] = 1'b1;
        build_model(1'b1, 100, 3, -1);
        chk1("pin2_len",    m_len, 333);
        chk1("pin2_hi206",  int'(exp_pie[206]), 1);
        chk1("pin2_lo207",  int'(exp_pie[207]), 0);
        chk1("pin2_hi219",  int'(exp_pie[219]), 1);
        chk1("pin2_lo251",  int'(exp_pie[251]), 0);
        chk1("pin2_nrdy",   count_rdy(), 3);
        run_frame(1'b1, 100, 3, -1, 1'b0);

        // underflow at the RTcal fetch
        tb_bits[0] = 1'b1;
        build_model(1'b0, 0, 1, 0);
        chk1("pin3_err119", int'(exp_err[119]), 1);
        run_frame(1'b0, 0, 1, 0, 1'b0);

        // rejected start
        run_frame(1'b1, 12, 2, -1, 1'b0);

        // re-pulsed start in DELIM and during data
        tb_bits[0] = 1'b1; tb_bits[1] = 1'b0; tb_bits[2] = 1'b1;
        run_frame(1'b1, 100, 3, -1, 1'b1);

        // reset during SYM_LO of the data-0 symbol, then a clean frame
        tb_bits[0] = 1'b0; tb_bits[1] = 1'b1;
        launch(1'b0, 0, 2, -1);
        for (int c = 0; c < 200 && idx < 41; c++) @(posedge clk);
        chk_on = 1'b0;
        #2;
        chk1("pre_rst_pie_lo", int'(pie_out), 0);
        reset = 1'b0;
        #1;
        chk1("async_rst_pie", int'(pie_out), 1);
        chk1("async_rst_busy", int'(busy), 0);
        #3 reset = 1'b1;
        run_frame(1'b0, 0, 2, -1, 1'b0);

        for (int f = 0; f < 8; f++) begin
            int nb, drop, tr;
            bit fp;
            nb = int'($urandom_range(1, 8));
            for (int i = 0; i < nb; i++) tb_bits[i] = 1'($urandom);
            fp = 1'($urandom);
            tr = int'($urandom_range(PW + 1, 300));
            drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
            run_frame(fp, tr, nb, drop, 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

endmodule
